// File: rtl/pipe_resp_pkg.sv
// Shared types and constants for the single-lane PIPE PHY responder.
// Optional build macro PIPE_RESP_ERRINJ_EN is consumed by the interface and top.
package pipe_resp_pkg;

    typedef enum logic [2:0] {
        ST_RST_HOLD = 3'd0,
        ST_IDLE     = 3'd1,
        ST_WAIT     = 3'd2,
        ST_PULSE    = 3'd3,
        ST_GAP      = 3'd4
    } resp_state_t;

    localparam logic [1:0] PD_P0  = 2'b00;
    localparam logic [1:0] PD_P0S = 2'b01;
    localparam logic [1:0] PD_P1  = 2'b10;
    localparam logic [1:0] PD_P2  = 2'b11;

    localparam logic [2:0] RXSTATUS_OK     = 3'b000;
    localparam logic [2:0] RXSTATUS_DET    = 3'b011;
    localparam logic [2:0] RXSTATUS_DECERR = 3'b100;

    localparam logic [7:0] ERR_BYTE = 8'hEE;

    // One beat travelling through the tx->rx loop pipeline.
    typedef struct packed {
        logic       err;
        logic       valid;
        logic       elecidle;
        logic       datak;
        logic [7:0] data;
    } loop_beat_t;

    localparam loop_beat_t LOOP_IDLE = '{err: 1'b0, valid: 1'b0, elecidle: 1'b1,
                                         datak: 1'b0, data: 8'h00};

    typedef struct packed {
        resp_state_t state;
        logic        det_pend;
        logic        pd_pend;
        logic        rate_pend;
        logic        armed;
        logic        txcompl;
    } resp_dbg_t;

    function automatic logic [7:0] lat_to_cnt(input int unsigned lat);
        return lat[7:0];
    endfunction

endpackage

// File: rtl/pipe_phy_resp_if.sv
// PIPE signal bundle between a MAC (master) and the PHY responder (slave).
// With PIPE_RESP_ERRINJ_EN defined, an extra err_inj request is carried.
interface pipe_phy_resp_if;
    // MAC-driven
    logic       rx_present;
    logic       loop_en;
    logic [7:0] txdata;
    logic       txdatak;
    logic       txelecidle;
    logic       txdetectrx;
    logic       txcompl;
    logic [1:0] powerdown;
    logic       rate;
    logic       rxpolarity;
`ifdef PIPE_RESP_ERRINJ_EN
    logic       err_inj;
`endif
    // PHY-driven. rxvalid qualifies rxdata/rxdatak in the same cycle; there is
    // no ready/backpressure, every beat with rxvalid=1 is consumed by the MAC.
    logic       phystatus;
    logic [2:0] rxstatus;
    logic [7:0] rxdata;
    logic       rxdatak;
    logic       rxvalid;
    logic       rxelecidle;

`ifdef PIPE_RESP_ERRINJ_EN
    modport master (
        output rx_present, loop_en, txdata, txdatak, txelecidle, txdetectrx,
               txcompl, powerdown, rate, rxpolarity, err_inj,
        input  phystatus, rxstatus, rxdata, rxdatak, rxvalid, rxelecidle
    );
    modport slave (
        input  rx_present, loop_en, txdata, txdatak, txelecidle, txdetectrx,
               txcompl, powerdown, rate, rxpolarity, err_inj,
        output phystatus, rxstatus, rxdata, rxdatak, rxvalid, rxelecidle
    );
`else
    modport master (
        output rx_present, loop_en, txdata, txdatak, txelecidle, txdetectrx,
               txcompl, powerdown, rate, rxpolarity,
        input  phystatus, rxstatus, rxdata, rxdatak, rxvalid, rxelecidle
    );
    modport slave (
        input  rx_present, loop_en, txdata, txdatak, txelecidle, txdetectrx,
               txcompl, powerdown, rate, rxpolarity,
        output phystatus, rxstatus, rxdata, rxdatak, rxvalid, rxelecidle
    );
`endif

endinterface

// File: rtl/pipe_resp_dly.sv
// Fixed-depth register pipeline; every stage resets to RST_VAL.
module pipe_resp_dly #(
    parameter int unsigned       DEPTH   = 2,
    parameter int unsigned       WIDTH   = 12,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/pipe_phy_resp.sv
// Single-lane PIPE PHY responder: phystatus sequencing plus tx->rx loopback.
// Define PIPE_RESP_ERRINJ_EN to add the err_inj decode-error injection input.
module pipe_phy_resp
    import pipe_resp_pkg::*;
#(
    parameter int unsigned RST_CYCLES = 16,
    parameter int unsigned DETECT_LAT = 20,
    parameter int unsigned PD_LAT     = 8,
    parameter int unsigned RATE_LAT   = 12,
    parameter int unsigned LOOP_LAT   = 2
) (
    input  logic           clk_clk,
    input  logic           reset_reset_n,
    pipe_phy_resp_if.slave pipe,
    output resp_dbg_t      dbg
);

    if (RST_CYCLES < 1 || RST_CYCLES > 255 || DETECT_LAT < 1 || DETECT_LAT > 255 ||
        PD_LAT < 1 || PD_LAT > 255 || RATE_LAT < 1 || RATE_LAT > 255) begin : g_bad_lat
        $error("pipe_phy_resp: latency parameters must be within 1..255");
    end
    if (LOOP_LAT < 1 || LOOP_LAT > 8) begin : g_bad_loop
        $error("pipe_phy_resp: LOOP_LAT must be within 1..8");
    end

    localparam logic [7:0] RST_CNT = lat_to_cnt(RST_CYCLES);
    localparam logic [7:0] DET_CNT = lat_to_cnt(DETECT_LAT);
    localparam logic [7:0] PD_CNT  = lat_to_cnt(PD_LAT);
    localparam logic [7:0] RT_CNT  = lat_to_cnt(RATE_LAT);

    resp_state_t state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        det_pend_q, det_pend_d;
    logic        pd_pend_q, pd_pend_d;
    logic        rate_pend_q, rate_pend_d;
    logic        armed_q, armed_d;
    logic        pulse_det_q, pulse_det_d;
    logic [1:0]  prev_pd_q;
    logic        prev_rate_q;
    logic        clr_det, clr_pd, clr_rate;
    logic        det_set, pd_set, rate_set;
    logic        in_hold;

    // Events are not captured while holding after reset, so pd/rate
    // changes seen there never turn into pulses after the hold ends.
    assign in_hold  = (state_q == ST_RST_HOLD);
    assign det_set  = !in_hold && armed_q && (pipe.powerdown == PD_P1) &&
                      pipe.txdetectrx && pipe.txelecidle;
    assign pd_set   = !in_hold && (pipe.powerdown != prev_pd_q);
    assign rate_set = !in_hold && (pipe.rate != prev_rate_q);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin : state_reg
        if (!reset_reset_n) begin
            state_q     <= ST_RST_HOLD;
            cnt_q       <= RST_CNT;
            det_pend_q  <= 1'b0;
            pd_pend_q   <= 1'b0;
            rate_pend_q <= 1'b0;
            armed_q     <= 1'b1;
            pulse_det_q <= 1'b0;
            prev_pd_q   <= PD_P0;
            prev_rate_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            det_pend_q  <= det_pend_d;
            pd_pend_q   <= pd_pend_d;
            rate_pend_q <= rate_pend_d;
            armed_q     <= armed_d;
            pulse_det_q <= pulse_det_d;
            prev_pd_q   <= pipe.powerdown;
            prev_rate_q <= pipe.rate;
        end
    end

    always_comb begin : next_state
        state_d     = state_q;
        cnt_d       = cnt_q;
        pulse_det_d = pulse_det_q;
        clr_det     = 1'b0;
        clr_pd      = 1'b0;
        clr_rate    = 1'b0;
        unique case (state_q)
            ST_RST_HOLD: begin
                if (cnt_q <= 8'd1) state_d = ST_IDLE;
                else               cnt_d   = cnt_q - 8'd1;
            end
            ST_IDLE: begin
                if (det_pend_q) begin
                    cnt_d = DET_CNT; clr_det = 1'b1; pulse_det_d = 1'b1; state_d = ST_WAIT;
                end else if (pd_pend_q) begin
                    cnt_d = PD_CNT; clr_pd = 1'b1; pulse_det_d = 1'b0; state_d = ST_WAIT;
                end else if (rate_pend_q) begin
                    cnt_d = RT_CNT; clr_rate = 1'b1; pulse_det_d = 1'b0; state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q <= 8'd1) state_d = ST_PULSE;
                else               cnt_d   = cnt_q - 8'd1;
            end
            ST_PULSE: state_d = ST_GAP;
            ST_GAP:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        // A fresh event in the cycle its flag is serviced must not be lost.
        det_pend_d  = (det_pend_q  && !clr_det)  || det_set;
        pd_pend_d   = (pd_pend_q   && !clr_pd)   || pd_set;
        rate_pend_d = (rate_pend_q && !clr_rate) || rate_set;
        armed_d     = !pipe.txdetectrx || (armed_q && !det_set);
    end

    // Loopback data path
    logic       loop_active;
    logic       err_req;
    loop_beat_t beat_in, beat_out;

`ifdef PIPE_RESP_ERRINJ_EN
    assign err_req = pipe.err_inj;
`else
    assign err_req = 1'b0;
`endif

    assign loop_active = pipe.loop_en && pipe.rx_present && (pipe.powerdown == PD_P0) &&
                         !pipe.txelecidle && !pipe.txdetectrx;

    always_comb begin
        beat_in = LOOP_IDLE;
        if (loop_active) begin
            beat_in.err      = err_req;
            beat_in.valid    = 1'b1;
            beat_in.elecidle = 1'b0;
            beat_in.datak    = pipe.txdatak;
            beat_in.data     = pipe.txdata ^ {8{pipe.rxpolarity}};
        end
    end

    pipe_resp_dly #(
        .DEPTH   (LOOP_LAT),
        .WIDTH   ($bits(loop_beat_t)),
        .RST_VAL (LOOP_IDLE)
    ) u_dly (
        .clk   (clk_clk),
        .rst_n (reset_reset_n),
        .d     (beat_in),
        .q     (beat_out)
    );

    always_comb begin : outputs
        pipe.phystatus  = (state_q == ST_RST_HOLD) || (state_q == ST_PULSE);
        pipe.rxstatus   = RXSTATUS_OK;
        if (state_q == ST_PULSE && pulse_det_q && pipe.rx_present)
            pipe.rxstatus = RXSTATUS_DET;
        pipe.rxdata     = beat_out.data;
        pipe.rxdatak    = beat_out.datak;
        pipe.rxvalid    = beat_out.valid;
        pipe.rxelecidle = beat_out.elecidle;
        // An injected error replaces the beat and takes priority on rxstatus.
        if (beat_out.err) begin
            pipe.rxdata   = ERR_BYTE;
            pipe.rxdatak  = 1'b0;
            pipe.rxvalid  = 1'b1;
            pipe.rxstatus = RXSTATUS_DECERR;
        end
    end

    assign dbg = '{state: state_q, det_pend: det_pend_q, pd_pend: pd_pend_q,
                   rate_pend: rate_pend_q, armed: armed_q, txcompl: pipe.txcompl};

endmodule

// File: tb/tb_pipe_phy_resp.sv
// Scoreboard bench for pipe_phy_resp: timestamped expected pulses and rx beats.
// Honours PIPE_RESP_ERRINJ_EN when the build defines it.
module tb_pipe_phy_resp;
    import pipe_resp_pkg::*;

    localparam int RST_CYCLES = 16;
    localparam int DETECT_LAT = 20;
    localparam int PD_LAT     = 8;
    localparam int RATE_LAT   = 12;
    localparam int LOOP_LAT   = 2;

    // Clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_phy_resp_if pipe ();
    resp_dbg_t dbg;

    pipe_phy_resp #(
        .RST_CYCLES (RST_CYCLES),
        .DETECT_LAT (DETECT_LAT),
        .PD_LAT     (PD_LAT),
        .RATE_LAT   (RATE_LAT),
        .LOOP_LAT   (LOOP_LAT)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .pipe          (pipe),
        .dbg           (dbg)
    );

    int checks = 0;
    int errors = 0;

    // Expected queues: pulse = {due[15:0], rxstatus[2:0]},
    // beat = {due[15:0], err, valid, elecidle, datak, data[7:0]}
    logic [18:0] exp_pulse_q[$];
    logic [27:0] exp_beat_q[$];

    // Reference model (edge-indexed, timestamp arithmetic)
    int         cyc;
    bit         m_det, m_pd, m_rate, m_armed;
    logic [1:0] m_prev_pd;
    logic       m_prev_rate;
    int         m_idle_from;
    int         m_lat;
    logic [2:0] m_st;
    logic [11:0] m_beat;
    logic       m_err;

    always @(posedge clk) begin
        if (!rst_n) begin
            cyc = 0; m_det = 0; m_pd = 0; m_rate = 0; m_armed = 1;
            m_prev_pd = PD_P0; m_prev_rate = 1'b0;
            m_idle_from = RST_CYCLES + 1;
            exp_pulse_q.delete();
            exp_beat_q.delete();
        end else begin
            cyc++;
            // A serviced request pulses LAT edges later, then one gap cycle.
            if (cyc >= m_idle_from && (m_det || m_pd || m_rate)) begin
                if (m_det) begin
                    m_lat = DETECT_LAT; m_det = 0;
                    m_st = pipe.rx_present ? RXSTATUS_DET : RXSTATUS_OK;
                end else if (m_pd) begin
                    m_lat = PD_LAT; m_pd = 0; m_st = RXSTATUS_OK;
                end else begin
                    m_lat = RATE_LAT; m_rate = 0; m_st = RXSTATUS_OK;
                end
                exp_pulse_q.push_back({16'(cyc + m_lat), m_st});
                m_idle_from = cyc + m_lat + 3;
            end
            if (cyc > RST_CYCLES) begin
                if (pipe.powerdown == PD_P1 && pipe.txdetectrx && pipe.txelecidle && m_armed) begin
                    m_det = 1; m_armed = 0;
                end
                if (pipe.powerdown != m_prev_pd) m_pd = 1;
                if (pipe.rate != m_prev_rate) m_rate = 1;
            end
            if (!pipe.txdetectrx) m_armed = 1;
            m_prev_pd   = pipe.powerdown;
            m_prev_rate = pipe.rate;
`ifdef PIPE_RESP_ERRINJ_EN
            m_err = pipe.err_inj;
`else
            m_err = 1'b0;
`endif
            if (pipe.loop_en && pipe.rx_present && pipe.powerdown == PD_P0 &&
                !pipe.txelecidle && !pipe.txdetectrx)
                m_beat = {m_err, 1'b1, 1'b0, pipe.txdatak,
                          pipe.txdata ^ (pipe.rxpolarity ? 8'hFF : 8'h00)};
            else
                m_beat = 12'h200;
            exp_beat_q.push_back({16'(cyc + LOOP_LAT - 1), m_beat});
        end
    end

    // Monitor / scoreboard
    logic        e_phy;
    logic [2:0]  e_st;
    logic [10:0] e_rx;
    logic [11:0] e_beat;
    logic [18:0] p_front;
    logic [27:0] b_front;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_phystatus", 16'(pipe.phystatus), 16'h1);
            check("reset_rxstatus", 16'(pipe.rxstatus), 16'h0);
            check("reset_rx", 16'({pipe.rxvalid, pipe.rxelecidle, pipe.rxdatak, pipe.rxdata}),
                  16'h200);
        end else begin
            e_phy = (cyc < RST_CYCLES);
            e_st  = RXSTATUS_OK;
            if (exp_pulse_q.size() > 0) begin
                p_front = exp_pulse_q[0];
                if (int'(p_front[18:3]) == cyc) begin
                    void'(exp_pulse_q.pop_front());
                    e_phy = 1'b1;
                    e_st  = p_front[2:0];
                end
            end
            e_beat = 12'h200;
            if (exp_beat_q.size() > 0) begin
                b_front = exp_beat_q[0];
                if (int'(b_front[27:12]) == cyc) begin
                    void'(exp_beat_q.pop_front());
                    e_beat = b_front[11:0];
                end
            end
            e_rx = e_beat[10:0];
            if (e_beat[11]) begin
                e_rx = {1'b1, 1'b0, 1'b0, ERR_BYTE};
                e_st = RXSTATUS_DECERR;
            end
            check("phystatus", 16'(pipe.phystatus), 16'(e_phy));
            check("rxstatus", 16'(pipe.rxstatus), 16'(e_st));
            check("rx_beat", 16'({pipe.rxvalid, pipe.rxelecidle, pipe.rxdatak, pipe.rxdata}),
                  16'(e_rx));
        end
    end

    // Driver tasks (inputs change 2ns after the active edge)
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic detect_req(input int hold);
        pipe.txelecidle = 1'b1;
        pipe.txdetectrx = 1'b1;
        step(hold);
        pipe.txdetectrx = 1'b0;
    endtask

    task automatic loop_beat(input logic [7:0] d, input logic k, input logic pol);
        pipe.txdata = d; pipe.txdatak = k; pipe.rxpolarity = pol;
        step(1);
    endtask

    initial begin
        pipe.rx_present = 1'b1; pipe.loop_en = 1'b0; pipe.txdata = 8'h00;
        pipe.txdatak = 1'b0; pipe.txelecidle = 1'b1; pipe.txdetectrx = 1'b0;
        pipe.txcompl = 1'b0; pipe.powerdown = PD_P0; pipe.rate = 1'b0;
        pipe.rxpolarity = 1'b0;
`ifdef PIPE_RESP_ERRINJ_EN
        pipe.err_inj = 1'b0;
`endif
        step(3);
        rst_n = 1'b1;
        step(30);

        // P0 -> P1, then receiver detect with and without a far-end receiver
        pipe.powerdown = PD_P1;
        step(15);
        detect_req(3);
        step(30);
        pipe.rx_present = 1'b0;
        step(2);
        detect_req(2);
        step(30);
        pipe.rx_present = 1'b1;

        // powerdown and rate change together -> two separate pulses
        pipe.powerdown = PD_P0; pipe.rate = 1'b1;
        step(40);
        pipe.rate = 1'b0;
        step(20);

        // Loopback: directed beats then random traffic
        pipe.loop_en = 1'b1; pipe.txelecidle = 1'b0;
        loop_beat(8'hBC, 1'b1, 1'b0);
        loop_beat(8'h0F, 1'b0, 1'b1);
        for (int i = 0; i < 60; i++) begin
            pipe.txelecidle = ($urandom_range(0, 9) == 0);
`ifdef PIPE_RESP_ERRINJ_EN
            pipe.err_inj = ($urandom_range(0, 7) == 0);
`endif
            loop_beat(8'($urandom), ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
        end
`ifdef PIPE_RESP_ERRINJ_EN
        pipe.err_inj = 1'b0;
`endif
        pipe.txelecidle = 1'b1;
        step(LOOP_LAT + 2);

        // Random mix of power/rate/detect/loop activity
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 24) == 0) pipe.powerdown = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) pipe.rate = ~pipe.rate;
            pipe.txdetectrx = ($urandom_range(0, 9) == 0);
            pipe.txelecidle = ($urandom_range(0, 3) == 0);
            pipe.loop_en    = ($urandom_range(0, 7) != 0);
            pipe.txcompl    = 1'($urandom_range(0, 1));
`ifdef PIPE_RESP_ERRINJ_EN
            pipe.err_inj    = ($urandom_range(0, 15) == 0);
`endif
            loop_beat(8'($urandom), ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
        end
        pipe.txdetectrx = 1'b0; pipe.loop_en = 1'b0;
`ifdef PIPE_RESP_ERRINJ_EN
        pipe.err_inj = 1'b0;
`endif
        step(80);

        // Reset in the middle of a detect wait: no stale pulse afterwards
        pipe.powerdown = PD_P1;
        step(15);
        detect_req(2);
        step(10);
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(60);

        check("pulse_queue_drained", 16'(exp_pulse_q.size()), 16'h0);
        checks++;
        if (exp_beat_q.size() > LOOP_LAT) begin
            errors++;
            $display("FAIL beat_queue_drained actual=%0d expected<=%0d",
                     exp_beat_q.size(), LOOP_LAT);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
